// File: rtl/vpu_rotate_if.sv
// Stream-side handshake bundle of the rotation stage: input vertex/angle and rotated output.
// The coefficient ROM connection stays on plain ports of vpu_rotate.
interface vpu_rotate_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x;
    logic signed [DW-1:0] in_y;
    logic [3:0]           in_angle;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_x;
    logic signed [DW-1:0] out_y;
    logic                 out_sat;

    modport master (
        output in_valid, in_x, in_y, in_angle, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_y, in_angle, out_ready,
        output in_ready, out_valid, out_x, out_y, out_sat
    );
endinterface

// File: rtl/vpu_rotate.sv
// vpu_rotate: 3-stage pipelined 2-D rotation by registered Q1.15 ROM coefficients.
// Define ROT_SAT_EN to clamp results to DW bits and flag out_sat; otherwise results wrap.
module vpu_rotate #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vpu_rotate_if.slave          io,
    output logic [3:0]           rom_addr,
    input  logic signed [CW-1:0] c1,
    input  logic signed [CW-1:0] c2,
    input  logic signed [CW-1:0] c3,
    input  logic signed [CW-1:0] c4
);
    localparam int PW = DW + CW;
    localparam int SW = PW + 1;
    localparam int FB = CW - 1;
    localparam int IW = SW - FB;
    localparam logic signed [SW-1:0] RND = {{(SW-FB){1'b0}}, 1'b1, {(FB-1){1'b0}}};

    logic                 en;
    logic                 take;
    logic                 v1;
    logic                 v2;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] y1;
    logic [3:0]           a1;
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic signed [PW-1:0] p3;
    logic signed [PW-1:0] p4;
    logic signed [SW-1:0] sx;
    logic signed [SW-1:0] sy;
    logic signed [IW-1:0] ix;
    logic signed [IW-1:0] iy;
    logic signed [DW-1:0] rx;
    logic signed [DW-1:0] ry;
    logic                 rsat;
    logic                 unused_bits;

    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en;
    assign take        = io.in_valid && en;

    // While stalled the ROM keeps re-reading the S1 angle, so c1..c4 stay aligned with x1/y1.
    assign rom_addr = take ? io.in_angle : a1;

    // Keeping the top IW bits of the rounded sum is the arithmetic shift by FB.
    assign sx = SW'(p1) + SW'(p2) + RND;
    assign sy = SW'(p3) + SW'(p4) + RND;
    assign ix = sx[SW-1:FB];
    assign iy = sy[SW-1:FB];

`ifdef ROT_SAT_EN
    function automatic logic [DW:0] clamp(input logic [IW-1:0] v);
        logic [DW:0] r;
        if (v[IW-1:DW-1] == {(IW-DW+1){v[IW-1]}})
            r = {1'b0, v[DW-1:0]};
        else if (v[IW-1])
            r = {1'b1, 1'b1, {(DW-1){1'b0}}};
        else
            r = {1'b1, 1'b0, {(DW-1){1'b1}}};
        return r;
    endfunction

    logic [DW:0] cx;
    logic [DW:0] cy;

    assign cx          = clamp(ix);
    assign cy          = clamp(iy);
    assign rx          = cx[DW-1:0];
    assign ry          = cy[DW-1:0];
    assign rsat        = cx[DW] | cy[DW];
    assign unused_bits = ^{sx[FB-1:0], sy[FB-1:0]};
`else
    assign rx          = ix[DW-1:0];
    assign ry          = iy[DW-1:0];
    assign rsat        = 1'b0;
    assign unused_bits = ^{sx[FB-1:0], sy[FB-1:0], ix[IW-1:DW], iy[IW-1:DW]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1           <= 1'b0;
            x1           <= '0;
            y1           <= '0;
            a1           <= '0;
            v2           <= 1'b0;
            p1           <= '0;
            p2           <= '0;
            p3           <= '0;
            p4           <= '0;
            io.out_valid <= 1'b0;
            io.out_x     <= '0;
            io.out_y     <= '0;
            io.out_sat   <= 1'b0;
        end else if (en) begin
            v1           <= io.in_valid;
            x1           <= io.in_x;
            y1           <= io.in_y;
            a1           <= io.in_angle;
            v2           <= v1;
            p1           <= PW'(c1) * PW'(x1);
            p2           <= PW'(c2) * PW'(y1);
            p3           <= PW'(c3) * PW'(x1);
            p4           <= PW'(c4) * PW'(y1);
            io.out_valid <= v2;
            io.out_x     <= rx;
            io.out_y     <= ry;
            io.out_sat   <= rsat;
        end
    end
endmodule
